// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Configuration macro used by the arbiter: MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int unsigned REQ_INST = 0;
  localparam int unsigned REQ_DATA = 1;
  localparam int unsigned REQ_LOAD = 2;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam int unsigned OWNER_W = 4;
  localparam logic [OWNER_W-1:0] OWNER_NONE = 4'hF;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int i = 0; i < 32; i++) begin
      width = ((32'd1 << i) < value) ? (i + 1) : width;
    end
    return width;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// One-hot picker: grants the first set request bit found when searching
// upward from index 'start', wrapping around at N.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] req_dbl_s;
  logic [2*N-1:0] gnt_dbl_s;
  logic [N-1:0]   req_rot_s;
  logic [N-1:0]   gnt_rot_s;

  // Rotate so 'start' lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl_s = {req, req} >> start;
    req_rot_s = req_dbl_s[N-1:0];
    gnt_rot_s = req_rot_s & (~req_rot_s + {{(N-1){1'b0}}, 1'b1});
    gnt_dbl_s = {gnt_rot_s, gnt_rot_s} << start;
    gnt       = gnt_dbl_s[2*N-1:N];
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between NREQ requesters with optional bursts.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, highest index wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned AW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*32-1:0] wdata,
  input  logic [NREQ*4-1:0]  wstrb,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [31:0]        rdata,
  output logic               mem_en,
  output logic [AW-3:0]      mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wstrb,
  input  logic [31:0]        mem_rdata
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = (clog2(LOCK_MAX) > 0) ? clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [CW-1:0]      lock_cnt_q, lock_cnt_d;
  logic               rd_pend_q, rd_pend_d;
  logic [IW-1:0]      rd_idx_q, rd_idx_d;

  logic [NREQ-1:0] pick_req_s, pick_gnt_s, win_oh_s, gnt_s;
  logic [IW-1:0]   pick_start_s, owner_idx_s, gidx_s;
  logic [AW-1:0]   addr_sel_s;
  logic [31:0]     wdata_sel_s;
  logic [3:0]      wstrb_sel_s;
  logic            owned_hold_s, grant_s;
  logic            unused_bits_s;

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin search begins at the pointer.
  always_comb begin
    pick_req_s   = req;
    pick_start_s = rr_ptr_q;
    win_oh_s     = pick_gnt_s;
  end
`else
  // Bit-reverse around a fixed start so the highest index has priority.
  always_comb begin
    pick_start_s = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      pick_req_s[i] = req[NREQ-1-i];
      win_oh_s[i]   = pick_gnt_s[NREQ-1-i];
    end
  end
`endif

  mem_arb_pick #(.N(NREQ), .SW(IW)) u_pick (
    .req   (pick_req_s),
    .start (pick_start_s),
    .gnt   (pick_gnt_s)
  );

  // Grant: the owner while it keeps requesting, otherwise the arbitration winner.
  always_comb begin
    owner_idx_s  = owner_q[IW-1:0];
    owned_hold_s = (state_q == ST_OWNED) && req[owner_idx_s];
    gnt_s        = '0;
    if (rst) begin
      gnt_s = '0;
    end else if (owned_hold_s) begin
      gnt_s[owner_idx_s] = 1'b1;
    end else begin
      gnt_s = win_oh_s;
    end
  end

  // One-hot mux of the granted requester's fields onto the RAM port.
  always_comb begin
    gidx_s      = '0;
    addr_sel_s  = '0;
    wdata_sel_s = 32'h0;
    wstrb_sel_s = 4'h0;
    for (int i = 0; i < int'(NREQ); i++) begin
      gidx_s      = gidx_s | (IW'(i) & {IW{gnt_s[i]}});
      addr_sel_s  = addr_sel_s | (addr[i*AW +: AW] & {AW{gnt_s[i]}});
      wdata_sel_s = wdata_sel_s | (wdata[i*32 +: 32] & {32{gnt_s[i]}});
      wstrb_sel_s = wstrb_sel_s | (wstrb[i*4 +: 4] & {4{gnt_s[i]}});
    end
    grant_s = |gnt_s;
  end

  // Output drive; rvalid comes from the read-pending flop and is squashed by reset.
  always_comb begin
    gnt           = gnt_s;
    mem_en        = grant_s;
    mem_addr      = addr_sel_s[AW-1:2];
    mem_wdata     = wdata_sel_s;
    mem_wstrb     = wstrb_sel_s;
    rdata         = mem_rdata;
    unused_bits_s = ^{addr_sel_s[1:0], owner_q[OWNER_W-1:IW]};
    for (int i = 0; i < int'(NREQ); i++) begin
      rvalid[i] = rd_pend_q & ~rst & (rd_idx_q == IW'(i));
    end
  end

  // Next-state: burst ownership, lock counting and read tracking.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (owned_hold_s) begin
      if (lock[owner_idx_s] && (lock_cnt_q < CNT_LAST)) begin
        lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        state_d    = ST_ARB;
        owner_d    = OWNER_NONE;
        lock_cnt_d = '0;
      end
    end else if (grant_s) begin
`ifdef MEM_ARB_RR_EN
      rr_ptr_d = (gidx_s == IW'(NREQ - 1)) ? '0 : gidx_s + IW'(1);
`endif
      if (lock[gidx_s] && (LOCK_MAX > 1)) begin
        state_d    = ST_OWNED;
        owner_d    = OWNER_W'(gidx_s);
        lock_cnt_d = CW'(1);
      end else begin
        state_d    = ST_ARB;
        owner_d    = OWNER_NONE;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = ST_ARB;
      owner_d    = OWNER_NONE;
      lock_cnt_d = '0;
    end
    rd_pend_d = grant_s & (wstrb_sel_s == 4'h0);
    rd_idx_d  = grant_s ? gidx_s : rd_idx_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      owner_q    <= OWNER_NONE;
      lock_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule
